serial_loader: RTL and testbench

SERIAL_LOADER -- requirements
Module: serial_loader

---
 rtl/serial_loader_pkg.sv | 13 +
 rtl/loader_shifter.sv | 55 +++++
 rtl/serial_loader.sv | 100 ++++++++++
 tb/tb_serial_loader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_loader_pkg.sv
// rtl/serial_loader_pkg.sv - FSM state encoding and default word width shared by serial_loader files
package serial_loader_pkg;

  localparam int SL_DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_CHECK  = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

endpackage

// File: rtl/loader_shifter.sv
// rtl/loader_shifter.sv - shadow shift register and saturating bit counter for serial_loader
module loader_shifter
  import serial_loader_pkg::*;
#(
  parameter int WIDTH     = SL_DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             restart,
  input  logic             shift_en,
  input  logic             ser_in,
  output logic [WIDTH-1:0] shadow_nxt,
  output logic             last_bit
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [CW-1:0]    count_q, count_d;
  logic             accept;

  // A full counter blocks further shifts, so the count never wraps within a frame.
  assign accept = shift_en && !restart && (count_q != CW'(WIDTH));

  always_comb begin
    shadow_d = shadow_q;
    count_d  = count_q;
    if (restart) begin
      shadow_d = '0;
      count_d  = '0;
    end else if (accept) begin
      if (LSB_FIRST) begin
        shadow_d = {ser_in, shadow_q[WIDTH-1:1]};
      end else begin
        shadow_d = {shadow_q[WIDTH-2:0], ser_in};
      end
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      shadow_q <= '0;
      count_q  <= '0;
    end else begin
      shadow_q <= shadow_d;
      count_q  <= count_d;
    end
  end

  assign shadow_nxt = shadow_d;
  assign last_bit   = accept && (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_loader.sv
// rtl/serial_loader.sv - serial-to-parallel register loader; SERIAL_LOADER_PARITY_EN adds an even-parity check bit
module serial_loader
  import serial_loader_pkg::*;
#(
  parameter int WIDTH     = SL_DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             frame_start,
  input  logic             ser_in,
  input  logic             ser_valid,
  output logic             ready,
  output logic             write_enable,
  output logic [WIDTH-1:0] input_val,
  output logic             frame_err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] input_val_q, input_val_d;
  logic             frame_err_q, frame_err_d;
  logic [WIDTH-1:0] shadow_nxt;
  logic             restart, shift_en, last_bit;

  // Kept outside the FSM process so the shifter's last_bit feedback forms no combinational loop.
  assign restart  = frame_start && (state_q != ST_COMMIT);
  assign shift_en = ser_valid && !frame_start && (state_q == ST_SHIFT);

  loader_shifter #(
    .WIDTH    (WIDTH),
    .LSB_FIRST(LSB_FIRST)
  ) u_shifter (
    .clk       (clk),
    .clear_n   (clear_n),
    .restart   (restart),
    .shift_en  (shift_en),
    .ser_in    (ser_in),
    .shadow_nxt(shadow_nxt),
    .last_bit  (last_bit)
  );

  always_comb begin
    state_d     = state_q;
    input_val_d = input_val_q;
    frame_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (frame_start) begin
          frame_err_d = 1'b1;
        end else if (last_bit) begin
`ifdef SERIAL_LOADER_PARITY_EN
          state_d = ST_CHECK;
`else
          state_d     = ST_COMMIT;
          input_val_d = shadow_nxt;
`endif
        end
      end
`ifdef SERIAL_LOADER_PARITY_EN
      ST_CHECK: begin
        if (frame_start) begin
          frame_err_d = 1'b1;
          state_d     = ST_SHIFT;
        end else if (ser_valid) begin
          if (^{shadow_nxt, ser_in}) begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            state_d     = ST_COMMIT;
            input_val_d = shadow_nxt;
          end
        end
      end
`endif
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= ST_IDLE;
      input_val_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      input_val_q <= input_val_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign ready        = (state_q == ST_SHIFT) || (state_q == ST_CHECK);
  assign write_enable = (state_q == ST_COMMIT);
  assign input_val    = input_val_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_serial_loader.sv
// tb/tb_serial_loader.sv - randomized self-checking bench for serial_loader, both bit orders, honours SERIAL_LOADER_PARITY_EN
module tb_serial_loader;

  localparam int W       = 32;
  localparam int NFRAMES = 60;

  logic clk = 1'b0;
  logic clear_n = 1'b0;
  logic frame_start = 1'b0;
  logic ser_in = 1'b0;
  logic ser_valid = 1'b0;
  logic rdy_l, we_l, err_l, rdy_m, we_m, err_m;
  logic [W-1:0] val_l, val_m;

  always #5 clk = ~clk;

  serial_loader #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .clear_n(clear_n), .frame_start(frame_start), .ser_in(ser_in),
    .ser_valid(ser_valid), .ready(rdy_l), .write_enable(we_l), .input_val(val_l),
    .frame_err(err_l)
  );

  serial_loader #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .clear_n(clear_n), .frame_start(frame_start), .ser_in(ser_in),
    .ser_valid(ser_valid), .ready(rdy_m), .write_enable(we_m), .input_val(val_m),
    .frame_err(err_m)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode 0 = waiting for a header, 1 = collecting bits, 2 = commit cycle.
  int           mode = 0;
  bit           bits_q[$];
  logic [W-1:0] exp_l = '0;
  logic [W-1:0] exp_m = '0;
  bit           exp_we = 1'b0;
  bit           exp_err = 1'b0;
  int           we_seen = 0;
  int           err_seen = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] assemble(input bit lsb);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++)
      if (bits_q[i]) w = w | (W'(1) << (lsb ? i : W - 1 - i));
    return w;
  endfunction

  task automatic model_commit();
    exp_l  = assemble(1'b1);
    exp_m  = assemble(1'b0);
    exp_we = 1'b1;
    mode   = 2;
  endtask

  task automatic model_edge(input bit fs, input bit v, input bit b);
    exp_we  = 1'b0;
    exp_err = 1'b0;
    if (mode == 2) begin
      mode = 0;
    end else if (fs) begin
      if (mode == 1) exp_err = 1'b1;
      mode = 1;
      bits_q.delete();
    end else if (mode == 1 && v) begin
      bits_q.push_back(b);
`ifdef SERIAL_LOADER_PARITY_EN
      if (bits_q.size() == W + 1) begin
        int ones;
        ones = 0;
        foreach (bits_q[i]) ones += int'(bits_q[i]);
        if (ones % 2 == 0) model_commit();
        else begin
          exp_err = 1'b1;
          mode    = 0;
        end
      end
`else
      if (bits_q.size() == W) model_commit();
`endif
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_ready_lsb"}, W'(rdy_l), W'(mode == 1));
    check_eq({tag, "_ready_msb"}, W'(rdy_m), W'(mode == 1));
    check_eq({tag, "_we_lsb"}, W'(we_l), W'(exp_we));
    check_eq({tag, "_we_msb"}, W'(we_m), W'(exp_we));
    check_eq({tag, "_err_lsb"}, W'(err_l), W'(exp_err));
    check_eq({tag, "_err_msb"}, W'(err_m), W'(exp_err));
    check_eq({tag, "_val_lsb"}, val_l, exp_l);
    check_eq({tag, "_val_msb"}, val_m, exp_m);
  endtask

  task automatic step(input bit fs, input bit v, input bit b);
    frame_start = fs;
    ser_valid   = v;
    ser_in      = b;
    @(posedge clk);
    model_edge(fs, v, b);
    #1;
    check_outputs("cyc");
    if (we_l) we_seen++;
    if (err_l) err_seen++;
  endtask

  task automatic send_bit(input bit b, input int gap_min, input int gap_max);
    repeat ($urandom_range(gap_min, gap_max)) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    step(1'b0, 1'b1, b);
  endtask

  task automatic send_frame(input logic [W-1:0] word, input int gap_min, input int gap_max,
                            input bit bad_par);
    step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < W; i++) send_bit(word[i], gap_min, gap_max);
`ifdef SERIAL_LOADER_PARITY_EN
    send_bit((^word) ^ bad_par, gap_min, gap_max);
`else
    if (bad_par) step(1'b0, 1'b0, 1'b0);
`endif
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    clear_n     = 1'b0;
    frame_start = 1'b0;
    ser_valid   = 1'b0;
    #1;
    mode = 0;
    bits_q.delete();
    exp_l   = '0;
    exp_m   = '0;
    exp_we  = 1'b0;
    exp_err = 1'b0;
    check_outputs("reset");
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    clear_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    logic [W-1:0] word;

    do_reset(3);

    we_seen = 0;
    send_frame(32'hA5A5_0001, 0, 0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check_eq("basic_we_count", W'(we_seen), W'(1));
    check_eq("basic_val", val_l, 32'hA5A5_0001);

    we_seen = 0;
    send_frame(32'hA5A5_0001, 1, 1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check_eq("alt_valid_we_count", W'(we_seen), W'(1));
    check_eq("alt_valid_val", val_l, 32'hA5A5_0001);

    we_seen  = 0;
    err_seen = 0;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)), 0, 0);
    send_frame(32'h0000_FFFF, 0, 0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check_eq("abort_err_count", W'(err_seen), W'(1));
    check_eq("abort_we_count", W'(we_seen), W'(1));
    check_eq("abort_val", val_l, 32'h0000_FFFF);

    send_frame(32'h1234_5678, 0, 0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
    check_eq("commit_fs_ready", W'(rdy_l), W'(0));
    check_eq("commit_fs_val", val_l, 32'h1234_5678);

    we_seen  = 0;
    err_seen = 0;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)), 0, 0);
    do_reset(3);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1);
    check_eq("reset_mid_we", W'(we_seen), W'(0));
    check_eq("reset_mid_err", W'(err_seen), W'(0));
    check_eq("reset_mid_val", val_l, 32'h0);

    send_frame(32'h0000_0001, 0, 0, 1'b0);
    check_eq("msb_first_val", val_m, 32'h8000_0000);
    check_eq("lsb_first_val", val_l, 32'h0000_0001);

`ifdef SERIAL_LOADER_PARITY_EN
    we_seen  = 0;
    err_seen = 0;
    send_frame(32'h0000_0001, 0, 0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check_eq("parity_bad_err", W'(err_seen), W'(1));
    check_eq("parity_bad_we", W'(we_seen), W'(0));
    check_eq("parity_bad_val", val_l, 32'h0000_0001);
`endif

    for (int f = 0; f < NFRAMES; f++) begin
      kind = int'($urandom_range(0, 5));
      word = W'($urandom);
      case (kind)
        0: begin
          step(1'b1, 1'b0, 1'b0);
          repeat ($urandom_range(1, W - 1)) send_bit(1'($urandom_range(0, 1)), 0, 2);
        end
        1: begin
          send_frame(word, 0, 2, 1'($urandom_range(0, 3) == 0));
          step(1'b1, 1'b1, 1'($urandom_range(0, 1)));
        end
        2: repeat ($urandom_range(1, 6)) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        3: begin
          step(1'b1, 1'b0, 1'b0);
          repeat ($urandom_range(0, W)) send_bit(1'($urandom_range(0, 1)), 0, 1);
          do_reset(int'($urandom_range(1, 3)));
        end
        default: send_frame(word, 0, 3, 1'($urandom_range(0, 3) == 0));
      endcase
    end
    repeat (3) step(1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
